// File: rtl/lcd_bus_driver_if.sv
// lcd_bus_driver_if: upstream valid/ready byte port plus the LCD pin bundle.
// The slave modport is the driver's view; master is the upstream/board side.
interface lcd_bus_driver_if;
  logic       i_valid;
  logic       o_ready;
  logic       i_rs;
  logic [7:0] i_data;
  logic       o_lcd_rs;
  logic       o_lcd_rw;
  logic       o_lcd_e;
  logic [7:0] o_lcd_db;
  logic       o_lcd_db_oe;
  logic [7:0] i_lcd_db;
  logic       o_timeout;

  modport slave (
    input  i_valid, i_rs, i_data, i_lcd_db,
    output o_ready, o_lcd_rs, o_lcd_rw, o_lcd_e, o_lcd_db, o_lcd_db_oe, o_timeout
  );

  modport master (
    output i_valid, i_rs, i_data, i_lcd_db,
    input  o_ready, o_lcd_rs, o_lcd_rw, o_lcd_e, o_lcd_db, o_lcd_db_oe, o_timeout
  );
endinterface

// File: rtl/lcd_bus_driver.sv
// lcd_bus_driver: HD44780 write-cycle sequencer. Takes one byte per handshake,
// applies setup / E pulse / hold on RS, DB and E, then waits for the controller
// to execute the command before accepting the next byte.
// Optional macro LCD_BUSY_FLAG_EN: replace the fixed execution wait by
// busy-flag polling (read cycles on DB7) with a timeout pulse.
module lcd_bus_driver #(
  parameter int CLOCK = 50_000_000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  lcd_bus_driver_if.slave    io_bus
);

  // ceil(CLOCK * num / den), evaluated at elaboration
  function automatic int cycles_for(input longint num, input longint den);
    longint prod;
    prod = longint'(CLOCK) * num;
    return int'((prod + den - 1) / den);
  endfunction

  function automatic int at_least_one(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  localparam int T_SETUP = at_least_one(cycles_for(60, 1_000_000_000));
  localparam int T_PW    = at_least_one(cycles_for(450, 1_000_000_000));
  localparam int T_HOLD  = at_least_one(cycles_for(20, 1_000_000_000));
  localparam int T_EXEC  = cycles_for(39, 1_000_000);
  localparam int T_LONG  = cycles_for(153, 100_000);
  localparam int CW      = $clog2(T_LONG + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t CNT_S    = cnt_t'(T_SETUP);
  localparam cnt_t CNT_P    = cnt_t'(T_PW);
  localparam cnt_t CNT_H    = cnt_t'(T_HOLD);
  localparam cnt_t CNT_EXEC = cnt_t'(T_EXEC);
  localparam cnt_t CNT_LONG = cnt_t'(T_LONG);
  localparam cnt_t CNT_ONE  = cnt_t'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT,
    ST_POLL_SETUP,
    ST_POLL_PULSE,
    ST_POLL_HOLD
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  cnt_t       r_cnt;
  cnt_t       w_load;
  logic       w_last;
  logic       w_accept;
  logic       r_rs;
  logic [7:0] r_data;
  logic       r_long;

  assign w_last   = (r_cnt == CNT_ONE);
  assign w_accept = (r_state == ST_IDLE) && io_bus.i_valid;

`ifdef LCD_BUSY_FLAG_EN
  logic r_flag;
  cnt_t r_poll_cnt;
  logic r_timeout;
  logic w_timeout;
  logic w_polling;
  logic w_poll_expired;

  assign w_polling      = (r_state == ST_POLL_SETUP) || (r_state == ST_POLL_PULSE) ||
                          (r_state == ST_POLL_HOLD);
  // r_poll_cnt holds the polling cycles already spent; this cycle is one more
  assign w_poll_expired = w_polling && (r_poll_cnt == CNT_LONG);
  assign io_bus.o_timeout = r_timeout;
`else
  logic w_unused_db;
  assign w_unused_db      = ^io_bus.i_lcd_db;
  assign io_bus.o_timeout = 1'b0;
`endif

  // State register and phase down-counter (reloaded whenever the state changes)
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_state_next != r_state) begin
        r_cnt <= w_load;
      end else if (r_state != ST_IDLE) begin
        r_cnt <= r_cnt - CNT_ONE;
      end
    end
  end

  // Capture the accepted byte and pre-decode whether it needs the long wait
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rs   <= 1'b0;
      r_data <= '0;
      r_long <= 1'b0;
    end else if (w_accept) begin
      r_rs   <= io_bus.i_rs;
      r_data <= io_bus.i_data;
      r_long <= !io_bus.i_rs && (io_bus.i_data >= 8'h01) && (io_bus.i_data <= 8'h03);
    end
  end

`ifdef LCD_BUSY_FLAG_EN
  // Busy-flag sample, total polling time and the one-cycle timeout pulse
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_flag     <= 1'b0;
      r_poll_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= w_timeout;
      if (r_state == ST_HOLD) begin
        r_poll_cnt <= '0;
      end else if (w_polling) begin
        r_poll_cnt <= r_poll_cnt + CNT_ONE;
      end
      if ((r_state == ST_POLL_PULSE) && w_last) begin
        r_flag <= io_bus.i_lcd_db[7];
      end
    end
  end
`endif

  // Next-state logic and the counter value for the state being entered
  always_comb begin
    w_state_next = r_state;
`ifdef LCD_BUSY_FLAG_EN
    w_timeout    = 1'b0;
`endif
    case (r_state)
      ST_IDLE:  if (io_bus.i_valid) w_state_next = ST_SETUP;
      ST_SETUP: if (w_last) w_state_next = ST_PULSE;
      ST_PULSE: if (w_last) w_state_next = ST_HOLD;
`ifdef LCD_BUSY_FLAG_EN
      ST_HOLD:  if (w_last) w_state_next = ST_POLL_SETUP;
`else
      ST_HOLD:  if (w_last) w_state_next = ST_WAIT;
`endif
      ST_WAIT:  if (w_last) w_state_next = ST_IDLE;
`ifdef LCD_BUSY_FLAG_EN
      ST_POLL_SETUP: if (w_last) w_state_next = ST_POLL_PULSE;
      ST_POLL_PULSE: if (w_last) w_state_next = ST_POLL_HOLD;
      ST_POLL_HOLD:  if (w_last) w_state_next = r_flag ? ST_POLL_SETUP : ST_IDLE;
`endif
      default:  w_state_next = ST_IDLE;
    endcase
`ifdef LCD_BUSY_FLAG_EN
    // A normal "not busy" exit wins over a simultaneous expiry
    if (w_poll_expired && (w_state_next != ST_IDLE)) begin
      w_state_next = ST_IDLE;
      w_timeout    = 1'b1;
    end
`endif
    w_load = CNT_ONE;
    case (w_state_next)
      ST_SETUP, ST_POLL_SETUP: w_load = CNT_S;
      ST_PULSE, ST_POLL_PULSE: w_load = CNT_P;
      ST_HOLD,  ST_POLL_HOLD:  w_load = CNT_H;
      ST_WAIT:                 w_load = r_long ? CNT_LONG : CNT_EXEC;
      default:                 w_load = CNT_ONE;
    endcase
  end

  // Pin values decoded from the current state
  always_comb begin
    io_bus.o_ready     = 1'b0;
    io_bus.o_lcd_rs    = 1'b0;
    io_bus.o_lcd_rw    = 1'b0;
    io_bus.o_lcd_e     = 1'b0;
    io_bus.o_lcd_db    = '0;
    io_bus.o_lcd_db_oe = 1'b0;
    case (r_state)
      ST_IDLE: io_bus.o_ready = 1'b1;
      ST_SETUP, ST_HOLD: begin
        io_bus.o_lcd_rs    = r_rs;
        io_bus.o_lcd_db    = r_data;
        io_bus.o_lcd_db_oe = 1'b1;
      end
      ST_PULSE: begin
        io_bus.o_lcd_rs    = r_rs;
        io_bus.o_lcd_db    = r_data;
        io_bus.o_lcd_db_oe = 1'b1;
        io_bus.o_lcd_e     = 1'b1;
      end
`ifdef LCD_BUSY_FLAG_EN
      ST_POLL_SETUP, ST_POLL_HOLD: io_bus.o_lcd_rw = 1'b1;
      ST_POLL_PULSE: begin
        io_bus.o_lcd_rw = 1'b1;
        io_bus.o_lcd_e  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lcd_bus_driver.sv
// tb_lcd_bus_driver: directed + randomized check of lcd_bus_driver at
// CLOCK=1 MHz. Expected pin values come from the timing rules (offsets from
// the acceptance edge), not from the design's state machine.
// Build with LCD_BUSY_FLAG_EN defined to exercise busy-flag polling instead.
module tb_lcd_bus_driver;
  localparam int S      = 1;
  localparam int P      = 1;
  localparam int H      = 1;
  localparam int T_EXEC = 39;
  localparam int T_LONG = 1530;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  lcd_bus_driver_if bus();

  lcd_bus_driver #(.CLOCK(1_000_000)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observation j after the acceptance edge (j=0 is right after it):
  // bus driven for j < S+P+H, E high for S <= j < S+P, ready again at j = S+P+H+W.
  task automatic do_write(input logic rs, input logic [7:0] data, input bit keep_valid,
                          input string tag);
    int w;
    int len;
    int pulses;
    w   = (!rs && (data == 8'h01 || data == 8'h02 || data == 8'h03)) ? T_LONG : T_EXEC;
    len = S + P + H + w;
    bus.i_valid = 1'b1;
    bus.i_rs    = rs;
    bus.i_data  = data;
    chk($sformatf("%s_ready_before", tag), bus.o_ready, 1);
    tick();
    if (!keep_valid) bus.i_valid = 1'b0;
    pulses = 0;
    for (int j = 0; j <= len; j++) begin
      if (!keep_valid) begin
        bus.i_rs   = 1'($urandom);
        bus.i_data = 8'($urandom);
      end
      chk($sformatf("%s_e_j%0d", tag, j), bus.o_lcd_e, (j >= S && j < S + P) ? 1 : 0);
      chk($sformatf("%s_ready_j%0d", tag, j), bus.o_ready, (j >= len) ? 1 : 0);
      chk($sformatf("%s_rw_j%0d", tag, j), bus.o_lcd_rw, 0);
      if (j < S + P + H) begin
        chk($sformatf("%s_oe_j%0d", tag, j), bus.o_lcd_db_oe, 1);
        chk($sformatf("%s_db_j%0d", tag, j), bus.o_lcd_db, data);
        chk($sformatf("%s_rs_j%0d", tag, j), bus.o_lcd_rs, rs);
      end else begin
        chk($sformatf("%s_oe_j%0d", tag, j), bus.o_lcd_db_oe, 0);
      end
      if (bus.o_lcd_e) pulses++;
      if (j < len) tick();
    end
    chk($sformatf("%s_pulse_count", tag), pulses, P);
    bus.i_rs   = 1'b0;
    bus.i_data = 8'h00;
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.o_lcd_e) pulses++;
    end
  endtask

`ifdef LCD_BUSY_FLAG_EN
  // DB7 reads busy while fewer than busy_polls+1 read pulses have been seen
  task automatic poll_case(input int busy_polls, output int polls, output int wpulses,
                           output int touts, output int j_ready);
    int j;
    bus.i_valid  = 1'b1;
    bus.i_rs     = 1'b0;
    bus.i_data   = 8'h28;
    bus.i_lcd_db = 8'h80;
    tick();
    bus.i_valid = 1'b0;
    polls = 0; wpulses = 0; touts = 0; j = 0;
    while (!bus.o_ready && j < 4000) begin
      if (bus.o_lcd_e && bus.o_lcd_rw) polls++;
      if (bus.o_lcd_e && !bus.o_lcd_rw) wpulses++;
      if (bus.o_timeout) touts++;
      bus.i_lcd_db = (polls <= busy_polls) ? 8'h80 : 8'h00;
      tick();
      j++;
    end
    j_ready = j;
    if (bus.o_timeout) touts++;
    tick();
    if (bus.o_timeout) touts++;
  endtask
`endif

  initial begin
    int pulses;
    bus.i_valid  = 1'b0;
    bus.i_rs     = 1'b0;
    bus.i_data   = 8'h00;
    bus.i_lcd_db = 8'h00;
    repeat (3) tick();

    chk("rst_ready", bus.o_ready, 1);
    chk("rst_e", bus.o_lcd_e, 0);
    chk("rst_rs", bus.o_lcd_rs, 0);
    chk("rst_rw", bus.o_lcd_rw, 0);
    chk("rst_db", bus.o_lcd_db, 0);
    chk("rst_oe", bus.o_lcd_db_oe, 0);
    chk("rst_timeout", bus.o_timeout, 0);
    rst = 1'b0;
    tick();

`ifdef LCD_BUSY_FLAG_EN
    begin
      int polls, wp, touts, jr;
      poll_case(2, polls, wp, touts, jr);
      chk("poll_reads", polls, 3);
      chk("poll_writes", wp, 1);
      chk("poll_timeouts", touts, 0);
      chk("poll_ready_at", jr, S + P + H + 3 * (S + P + H));
      chk("poll_rw_idle", bus.o_lcd_rw, 0);
      poll_case(1_000_000, polls, wp, touts, jr);
      chk("stuck_timeouts", touts, 1);
      chk("stuck_writes", wp, 1);
      chk("stuck_idle", bus.o_ready, 1);
      chk("stuck_rw_idle", bus.o_lcd_rw, 0);
      chk("stuck_e_idle", bus.o_lcd_e, 0);
    end
`else
    do_write(1'b1, 8'h41, 1'b0, "data41");
    do_write(1'b0, 8'h01, 1'b0, "clear01");
    do_write(1'b0, 8'h02, 1'b0, "home02");
    do_write(1'b0, 8'h03, 1'b0, "home03");
    do_write(1'b0, 8'h80, 1'b0, "ddram80");

    // back-to-back, i_valid held with stable inputs
    for (int b = 0; b < 3; b++) do_write(1'b1, 8'h5A, 1'b1, $sformatf("b2b%0d", b));
    bus.i_valid = 1'b0;
    count_pulses(60, pulses);
    chk("b2b_no_extra_pulse", pulses, 0);

    // reset while E is high
    bus.i_valid = 1'b1;
    bus.i_rs    = 1'b1;
    bus.i_data  = 8'hA5;
    tick();
    bus.i_valid = 1'b0;
    repeat (S) tick();
    chk("rstmid_e_high", bus.o_lcd_e, 1);
    rst = 1'b1;
    tick();
    chk("rstmid_e", bus.o_lcd_e, 0);
    chk("rstmid_ready", bus.o_ready, 1);
    chk("rstmid_oe", bus.o_lcd_db_oe, 0);
    rst = 1'b0;
    count_pulses(60, pulses);
    chk("rstmid_no_pulse", pulses, 0);

    // randomized bytes, biased toward the long-wait instructions
    for (int r = 0; r < 8; r++) begin
      logic       rrs;
      logic [7:0] rdata;
      rrs   = 1'($urandom_range(0, 1));
      rdata = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 3)) : 8'($urandom);
      $display("rand %0d: rs=%0d data=%02h", r, rrs, rdata);
      do_write(rrs, rdata, 1'b0, $sformatf("rand%0d", r));
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
